// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if
//   Bundles the requester handshake, the stall input and the registered
//   register-file write port of rf_write_arbiter.
//   Parameters NREQ/ADDR_W/DATA_W must match the arbiter instance.
//   Signals:
//     req_valid  [NREQ]         per-requester write request
//     req_addr   [NREQ*ADDR_W]  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//     req_data   [NREQ*DATA_W]  packed data, requester i at [i*DATA_W +: DATA_W]
//     req_ready  [NREQ]         one-hot grant (combinational)
//     rf_stall                  blocks new grants
//     rf_we / rf_addr_wr / rf_data / rf_src  registered write toward the register file
//   Modports: master = requesters + register file side, slave = arbiter.
interface rf_write_arbiter_if #(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   rf_stall;
    logic                   rf_we;
    logic [ADDR_W-1:0]      rf_addr_wr;
    logic [DATA_W-1:0]      rf_data;
    logic [1:0]             rf_src;

    modport master (
        output req_valid, req_addr, req_data, rf_stall,
        input  req_ready, rf_we, rf_addr_wr, rf_data, rf_src
    );

    modport slave (
        input  req_valid, req_addr, req_data, rf_stall,
        output req_ready, rf_we, rf_addr_wr, rf_data, rf_src
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Round-robin arbiter sharing the single register-file write port between
//   NREQ (2..4) writeback requesters. At most one grant per clock; the granted
//   address/data/source are registered so the write reaches the register file
//   one cycle after the grant.
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous active-high reset
//     bus   rf_write_arbiter_if.slave (handshake, stall, registered write port)
//   Optional feature: define RF_ARB_ZERO_PROTECT_EN to drop (rf_we=0) granted
//   writes whose address is 0; the handshake and pointer advance still occur.
module rf_write_arbiter #(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    rf_write_arbiter_if.slave bus
);
    localparam int unsigned     PTR_W  = (NREQ > 2) ? 2 : 1;
    localparam logic [PTR_W:0]  NREQ_W = (PTR_W+1)'(NREQ);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        src_q;

    logic [PTR_W:0]    cand;
    logic [PTR_W-1:0]  idx;
    logic              gvalid;
    logic [PTR_W-1:0]  gidx;
    logic [NREQ-1:0]   grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Rotating search starting at the pointer; the first valid requester wins.
    always_comb begin
        cand   = '0;
        idx    = '0;
        gvalid = 1'b0;
        gidx   = '0;
        grant  = '0;
        if (!rst && !bus.rf_stall) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                // pointer + k, folded back into 0..NREQ-1
                cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
                if (cand >= NREQ_W) begin
                    cand = cand - NREQ_W;
                end
                idx = cand[PTR_W-1:0];
                if (!gvalid && bus.req_valid[idx]) begin
                    gvalid = 1'b1;
                    gidx   = idx;
                end
            end
            if (gvalid) begin
                grant = NREQ'(1) << gidx;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gvalid) begin
            ptr_d = (gidx == LAST) ? '0 : gidx + 1'b1;
        end
`ifdef RF_ARB_ZERO_PROTECT_EN
        // Writes to $zero complete the handshake but never reach the file.
        we_d = gvalid && (sel_addr != '0);
`else
        we_d = gvalid;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            src_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            we_q  <= we_d;
            // Address/data/source hold their last values on idle cycles.
            if (gvalid) begin
                addr_q <= sel_addr;
                data_q <= sel_data;
                src_q  <= 2'(gidx);
            end
        end
    end

    assign bus.req_ready  = grant;
    assign bus.rf_we      = we_q;
    assign bus.rf_addr_wr = addr_q;
    assign bus.rf_data    = data_q;
    assign bus.rf_src     = src_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
    localparam int NREQ   = 3;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;

    rf_write_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rf_write_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester-side stimulus
    logic              va [NREQ];
    logic [ADDR_W-1:0] aa [NREQ];
    logic [DATA_W-1:0] dd [NREQ];
    logic              stall;

    // Reference model state
    int                m_ptr;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    int                m_src;

    logic [NREQ-1:0]   last_ready;
    int                last_grant;

    // Winner by the rotating-priority rule: first valid requester at or after m_ptr.
    function automatic int pick();
        if (rst || stall) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (va[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i] = va[i];
            bus.req_addr[i*ADDR_W +: ADDR_W] = aa[i];
            bus.req_data[i*DATA_W +: DATA_W] = dd[i];
        end
        bus.rf_stall = stall;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: apply inputs, compare against the model, advance the model.
    task automatic step();
        int g;
        logic [NREQ-1:0] er;
        drive();
        #1;
        g  = pick();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("ready",  64'(bus.req_ready), 64'(er));
        chk("rf_we",  64'(bus.rf_we),     64'(m_we));
        chk("rf_addr",64'(bus.rf_addr_wr),64'(m_addr));
        chk("rf_data",64'(bus.rf_data),   64'(m_data));
        chk("rf_src", 64'(bus.rf_src),    64'(m_src));
        last_ready = bus.req_ready;
        last_grant = g;
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_src = 0;
        end else begin
            m_we = (g >= 0);
            if (g >= 0) begin
`ifdef RF_ARB_ZERO_PROTECT_EN
                if (aa[g] == '0) m_we = 1'b0;
`endif
                m_addr = aa[g];
                m_data = dd[g];
                m_src  = g;
                m_ptr  = (g + 1) % NREQ;
            end
        end
        #1;
    endtask

    task automatic set_valid(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) va[i] = v[i];
    endtask

    initial begin
        stall = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            va[i] = 1'b1;
            aa[i] = ADDR_W'(i + 1);
            dd[i] = DATA_W'(32'h1000 * (i + 1));
        end
        rst = 1'b1;
        drive();
        @(posedge clk);
        #1;
        m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_src = 0;

        // Reset held with every requester valid
        step();
        chk("rst_ready", 64'(last_ready), 64'(0));
        step();
        chk("rst_ready2", 64'(last_ready), 64'(0));
        chk("rst_we", 64'(bus.rf_we), 64'(0));
        rst = 1'b0;
        step();
        chk("first_grant", 64'(last_ready), 64'(3'b001));

        // Single requester
        set_valid(3'b010);
        aa[1] = 4'd5; dd[1] = 32'd100;
        step();
        chk("single_ready", 64'(last_ready), 64'(3'b010));
        chk("single_we",   64'(bus.rf_we),      64'(1));
        chk("single_addr", 64'(bus.rf_addr_wr), 64'(5));
        chk("single_data", 64'(bus.rf_data),    64'(100));
        chk("single_src",  64'(bus.rf_src),     64'(1));

        // Bring pointer to 0, then fairness over 6 cycles
        set_valid(3'b100);
        step();
        set_valid(3'b111);
        for (int i = 0; i < NREQ; i++) begin
            aa[i] = ADDR_W'(8 + i);
            dd[i] = DATA_W'(32'hA000 + i);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            chk("fair_order", 64'(last_ready), 64'(1 << (c % 3)));
            chk("fair_data",  64'(bus.rf_data), 64'(32'hA000 + (c % 3)));
        end

        // Stall with all requesters valid
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_ready", 64'(last_ready), 64'(0));
            chk("stall_we",    64'(bus.rf_we),  64'(0));
        end
        stall = 1'b0;
        step();
        chk("stall_resume", 64'(last_ready), 64'(3'b001));

        // Pointer to 2, then wrap/skip with req0 and req2
        set_valid(3'b010);
        step();
        set_valid(3'b101);
        step();
        chk("wrap_a", 64'(last_ready), 64'(3'b100));
        step();
        chk("wrap_b", 64'(last_ready), 64'(3'b001));
        step();
        chk("wrap_c", 64'(last_ready), 64'(3'b100));

        // Write to address 0
        set_valid(3'b001);
        aa[0] = '0; dd[0] = 32'hDEAD;
        step();
        chk("zero_ready", 64'(last_ready), 64'(3'b001));
`ifdef RF_ARB_ZERO_PROTECT_EN
        chk("zero_we", 64'(bus.rf_we), 64'(0));
`else
        chk("zero_we", 64'(bus.rf_we), 64'(1));
`endif
        set_valid(3'b000);
        step();
        chk("idle_we",   64'(bus.rf_we),   64'(0));
        chk("idle_hold", 64'(bus.rf_data), 64'(32'hDEAD));

        // Randomized traffic: pending requests hold until granted or withdrawn
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!va[i] || i == last_grant || $urandom_range(0, 9) == 0) begin
                    va[i] = ($urandom_range(0, 2) != 0);
                    aa[i] = ADDR_W'($urandom);
                    dd[i] = $urandom;
                end
            end
            stall = ($urandom_range(0, 4) == 0);
            rst   = ($urandom_range(0, 39) == 0);
            step();
        end
        rst = 1'b0;
        stall = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
